program_loader: RTL and testbench

- Boot-time loader upstream of the KGP-RISC core.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words sequentially into instruction memory from address 0.
- Holds the core in reset through cpu_rst until a complete, checksum-verified image is loaded.

---
 rtl/kgp_loader_pkg.sv | 17 +
 rtl/byte_word_assembler.sv | 67 ++++++
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_loader_pkg.sv
// Shared definitions for the KGP-RISC boot-time program loader.
package kgp_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int LANES     = 4;
  localparam int LANE_W    = $clog2(LANES);
  localparam int HDR_WIDTH = 16;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs big-endian bytes into 32-bit words and keeps a running XOR of every
// byte it has accepted. word_valid pulses for one cycle after the 4th byte.
module byte_word_assembler
  import kgp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [7:0]        byte_in,
  output logic [31:0]       word,
  output logic              word_valid,
  output logic [7:0]        checksum,
  output logic              last_lane
);

  logic [8*(LANES-1)-1:0] shift_q, shift_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [31:0]            word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic [7:0]             csum_q, csum_d;

  assign last_lane  = (lane_q == LANE_W'(LANES - 1));
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign checksum   = csum_q;

  // Shift, lane count and checksum update for one accepted byte.
  always_comb begin
    shift_d      = shift_q;
    lane_d       = lane_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    csum_d       = csum_q;
    if (clear) begin
      shift_d = '0;
      lane_d  = '0;
      csum_d  = '0;
    end else if (en) begin
      shift_d = {shift_q[8*(LANES-2)-1:0], byte_in};
      lane_d  = lane_q + LANE_W'(1);
      csum_d  = csum_q ^ byte_in;
      if (last_lane) begin
        word_d       = {shift_q, byte_in};
        word_valid_d = 1'b1;
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      csum_q       <= '0;
    end else begin
      shift_q      <= shift_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      csum_q       <= csum_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a counted, XOR-protected byte frame into instruction
// memory from address 0 and keeps the core in reset until it verifies.
//
// state     | meaning
// HDR_HI    | waiting for COUNT[15:8]
// HDR_LO    | waiting for COUNT[7:0], header range check
// DATA      | receiving 4*COUNT instruction bytes
// CHECK     | waiting for the XOR checksum byte
// DONE      | image verified, core released
// ERROR     | bad header or checksum, core held in reset
module program_loader
  import kgp_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int                   DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [HDR_WIDTH:0]   DEPTH_EXT = (HDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  WL_ONE    = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [HDR_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  accept;
  logic                  reload_hit;
  logic                  asm_clear;
  logic                  asm_en;
  logic                  asm_last_lane;
  logic                  word_last_byte;
  logic                  last_word;
  logic                  hdr_bad;
  logic [HDR_WIDTH-1:0]  count_full;
  logic [31:0]           asm_word;
  logic                  asm_valid;
  logic [7:0]            asm_csum;

  assign accept         = byte_valid && byte_ready;
  assign reload_hit     = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign asm_en         = accept && (state_q == ST_DATA);
  assign word_last_byte = asm_en && asm_last_lane;
  assign count_full     = {count_q[HDR_WIDTH-1:8], byte_in};
  assign hdr_bad        = (count_full == '0) || ({1'b0, count_full} > DEPTH_EXT);
  // Count is already range-checked, so its low ADDR_WIDTH+1 bits hold it exactly.
  assign last_word      = ((wl_q + WL_ONE) == count_q[ADDR_WIDTH:0]);

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .en         (asm_en),
    .byte_in    (byte_in),
    .word       (asm_word),
    .word_valid (asm_valid),
    .checksum   (asm_csum),
    .last_lane  (asm_last_lane)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HDR_HI;
    else     state_q <= state_d;
  end

  // Next-state logic, header latch and assembler clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_HDR_HI: if (accept) begin
        count_d[HDR_WIDTH-1:8] = byte_in;
        state_d                = ST_HDR_LO;
      end
      ST_HDR_LO: if (accept) begin
        count_d   = count_full;
        asm_clear = 1'b1;
        state_d   = hdr_bad ? ST_ERROR : ST_DATA;
      end
      ST_DATA: if (word_last_byte && last_word) state_d = ST_CHECK;
      ST_CHECK: if (accept) state_d = (byte_in == asm_csum) ? ST_DONE : ST_ERROR;
      ST_DONE, ST_ERROR: if (reload_hit) begin
        state_d   = ST_HDR_HI;
        count_d   = '0;
        asm_clear = 1'b1;
      end
      default: state_d = ST_HDR_HI;
    endcase
  end

  // Output decode from state; ready is forced low while reset is held.
  always_comb begin
    byte_ready = !rst && ((state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                          (state_q == ST_DATA)   || (state_q == ST_CHECK));
    cpu_rst    = (state_q != ST_DONE);
    load_done  = (state_q == ST_DONE);
    load_error = (state_q == ST_ERROR);
  end

  // Word counter and write address advance together with the write strobe.
  always_comb begin
    wl_d   = wl_q;
    addr_d = addr_q;
    if (reload_hit) begin
      wl_d   = '0;
      addr_d = '0;
    end else if (word_last_byte) begin
      addr_d = wl_q[ADDR_WIDTH-1:0];
      wl_d   = wl_q + WL_ONE;
    end
  end

  // Header count, word counter and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
    end else begin
      count_q <= count_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_we      = asm_valid;
  assign imem_wdata   = asm_word;
  assign imem_addr    = addr_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_program_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame-level model: byte index within the frame decides what each byte means.
  bit          m_rx, m_done, m_err, m_we;
  int          m_idx, m_cnt, m_wl, m_addr;
  logic [7:0]  m_xor;
  logic [31:0] m_word, m_wdata;

  task automatic model_reset();
    m_rx = 1; m_done = 0; m_err = 0; m_we = 0;
    m_idx = 0; m_cnt = 0; m_wl = 0; m_addr = 0;
    m_xor = 8'h00; m_word = 32'h0; m_wdata = 32'h0;
  endtask

  task automatic model_step(input bit acc, input logic [7:0] b, input bit rl);
    m_we = 0;
    if (m_rx && acc) begin
      if (m_idx == 0) begin
        m_cnt = int'(b) * 256; m_idx = 1;
      end else if (m_idx == 1) begin
        m_cnt = m_cnt + int'(b); m_idx = 2;
        if (m_cnt == 0 || m_cnt > (1 << AW)) begin m_rx = 0; m_err = 1; end
      end else if (m_idx < 2 + 4 * m_cnt) begin
        m_xor  = m_xor ^ b;
        m_word = {m_word[23:0], b};
        m_idx++;
        if ((m_idx - 2) % 4 == 0) begin
          m_we = 1; m_addr = m_wl; m_wdata = m_word; m_wl++;
        end
      end else begin
        m_rx = 0;
        if (b == m_xor) m_done = 1; else m_err = 1;
      end
    end else if (!m_rx && rl) begin
      model_reset();
    end
  endtask

  int          lg_a[$];
  logic [31:0] lg_d[$];
  bit          last_acc = 0;

  // Per-cycle comparison against the model, then advance it with this cycle's inputs.
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("byte_ready",   32'(byte_ready),   32'(m_rx && !rst));
    chk("cpu_rst",      32'(cpu_rst),      32'(!m_done));
    chk("load_done",    32'(load_done),    32'(m_done));
    chk("load_error",   32'(load_error),   32'(m_err));
    chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    chk("imem_we",      32'(imem_we),      32'(m_we));
    if (m_we) begin
      chk("imem_addr",  32'(imem_addr),    32'(m_addr));
      chk("imem_wdata", imem_wdata,        m_wdata);
    end
    if (imem_we === 1'b1) begin
      lg_a.push_back(int'(imem_addr));
      lg_d.push_back(imem_wdata);
    end
    last_acc = byte_valid && byte_ready;
    if (!rst) model_step(byte_valid && m_rx, byte_in, reload);
  end

  logic [7:0]  tx[$];
  logic [31:0] fw[0:3];

  task automatic make_frame(input int n, input logic [7:0] flip);
    logic [7:0] x, b;
    tx.delete();
    tx.push_back(8'(n >> 8));
    tx.push_back(8'(n));
    x = 8'h00;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) begin
        b = fw[k][31 - 8*j -: 8];
        tx.push_back(b);
        x = x ^ b;
      end
    tx.push_back(x ^ flip);
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accept.
  task automatic send(input int gap, input int budget, output bit ok);
    int i = 0;
    int cyc = 0;
    ok = 1;
    while (i < tx.size()) begin
      byte_in    = tx[i];
      byte_valid = ($urandom_range(99) >= gap);
      @(posedge clk); #1;
      if (last_acc) i++;
      cyc++;
      if (cyc > budget) begin ok = 0; break; end
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_wl",      32'(words_loaded), 32'd0);
    chk("reload_done",    32'(load_done), 32'd0);
    chk("reload_ready",   32'(byte_ready), 32'd1);
  endtask

  task automatic frame_a();
    fw[0] = 32'h20010005;
    fw[1] = 32'h24020007;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ref_a[$];
    logic [31:0] ref_d[$];
    byte_valid = 1'b0; byte_in = 8'h00; reload = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ready",   32'(byte_ready), 32'd0);
    chk("rst_we",      32'(imem_we), 32'd0);
    chk("rst_done",    32'(load_done), 32'd0);
    chk("rst_err",     32'(load_error), 32'd0);
    chk("rst_wl",      32'(words_loaded), 32'd0);
    chk("rst_addr",    32'(imem_addr), 32'd0);
    chk("rst_wdata",   imem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Good 2-word frame, no gaps.
    frame_a(); make_frame(2, 8'h00);
    chk("A_csum", 32'(tx[tx.size()-1]), 32'h05);
    lg_a.delete(); lg_d.delete();
    send(0, 100, ok); chk("A_send", 32'(ok), 32'd1);
    chk("A_done",    32'(load_done), 32'd1);
    chk("A_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("A_wl",      32'(words_loaded), 32'd2);
    chk("A_nwr",     32'(lg_a.size()), 32'd2);
    if (lg_a.size() == 2) begin
      chk("A_a0", 32'(lg_a[0]), 32'd0); chk("A_d0", lg_d[0], 32'h20010005);
      chk("A_a1", 32'(lg_a[1]), 32'd1); chk("A_d1", lg_d[1], 32'h24020007);
    end

    // Same frame, bad checksum; extra bytes must be refused.
    do_reload();
    make_frame(2, 8'h01);
    send(0, 100, ok); chk("B_send", 32'(ok), 32'd1);
    chk("B_err",     32'(load_error), 32'd1);
    chk("B_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("B_ready",   32'(byte_ready), 32'd0);
    tx.delete(); tx.push_back(8'h11); tx.push_back(8'h22);
    send(0, 8, ok); chk("B_extra_refused", 32'(ok), 32'd0);
    chk("B_err_hold", 32'(load_error), 32'd1);

    // Header out of range: zero and DEPTH+1.
    do_reload();
    lg_a.delete(); lg_d.delete();
    tx.delete(); tx.push_back(8'h00); tx.push_back(8'h00);
    send(0, 20, ok); chk("H0_send", 32'(ok), 32'd1);
    chk("H0_err",   32'(load_error), 32'd1);
    chk("H0_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(posedge clk); #1;
    do_reload();
    tx.delete(); tx.push_back(8'h04); tx.push_back(8'h01);
    send(0, 20, ok); chk("H1025_send", 32'(ok), 32'd1);
    chk("H1025_err", 32'(load_error), 32'd1);
    repeat (3) @(posedge clk); #1;
    chk("H_no_writes", 32'(lg_a.size()), 32'd0);

    // Random 3-word frame without and with gaps.
    for (int k = 0; k < 3; k++) fw[k] = $urandom;
    do_reload();
    make_frame(3, 8'h00);
    lg_a.delete(); lg_d.delete();
    send(0, 100, ok); chk("R0_send", 32'(ok), 32'd1);
    chk("R0_done", 32'(load_done), 32'd1);
    chk("R0_nwr",  32'(lg_a.size()), 32'd3);
    ref_a = lg_a; ref_d = lg_d;
    do_reload();
    lg_a.delete(); lg_d.delete();
    send(50, 400, ok); chk("R1_send", 32'(ok), 32'd1);
    chk("R1_done", 32'(load_done), 32'd1);
    chk("R1_nwr",  32'(lg_a.size()), 32'(ref_a.size()));
    for (int k = 0; k < 3; k++)
      if (k < lg_a.size() && k < ref_a.size()) begin
        chk("R_addr", 32'(lg_a[k]), 32'(k));
        chk("R_data", lg_d[k], ref_d[k]);
        chk("R_data_src", lg_d[k], fw[k]);
      end

    // Reload from DONE and load a 1-word frame over address 0.
    do_reload();
    fw[0] = 32'hDEADBEEF; make_frame(1, 8'h00);
    chk("C_csum", 32'(tx[tx.size()-1]), 32'h22);
    lg_a.delete(); lg_d.delete();
    send(0, 100, ok); chk("C_send", 32'(ok), 32'd1);
    chk("C_done", 32'(load_done), 32'd1);
    chk("C_nwr",  32'(lg_a.size()), 32'd1);
    if (lg_a.size() == 1) begin
      chk("C_a0", 32'(lg_a[0]), 32'd0); chk("C_d0", lg_d[0], 32'hDEADBEEF);
    end

    // Async reset mid-frame, then a full reload from address 0.
    do_reload();
    frame_a(); make_frame(2, 8'h00);
    while (tx.size() > 6) void'(tx.pop_back());
    send(0, 50, ok); chk("P_send", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("P_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("P_ready",   32'(byte_ready), 32'd0);
    chk("P_we",      32'(imem_we), 32'd0);
    chk("P_wl",      32'(words_loaded), 32'd0);
    chk("P_addr",    32'(imem_addr), 32'd0);
    chk("P_err",     32'(load_error), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    make_frame(2, 8'h00);
    lg_a.delete(); lg_d.delete();
    send(0, 100, ok); chk("P2_send", 32'(ok), 32'd1);
    chk("P2_done", 32'(load_done), 32'd1);
    chk("P2_wl",   32'(words_loaded), 32'd2);
    if (lg_a.size() == 2) begin
      chk("P2_a0", 32'(lg_a[0]), 32'd0); chk("P2_d0", lg_d[0], 32'h20010005);
      chk("P2_a1", 32'(lg_a[1]), 32'd1); chk("P2_d1", lg_d[1], 32'h24020007);
    end else chk("P2_nwr", 32'(lg_a.size()), 32'd2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
